// File: rtl/fft32_pkg.sv
// Shared FFT-32 definitions: sizes, number formats, FSM encoding and the
// twiddle-exponent / rounding helpers used by the twiddle scheduler.
package fft32_pkg;

    localparam int FFT_N   = 32;
    localparam int LOG2N   = 5;
    localparam int IN_W    = 18;
    localparam int TW_W    = 20;
    localparam int TW_FRAC = 18;
    localparam int OUT_W   = IN_W + 1;
    localparam int PROD_W  = IN_W + TW_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Stage numbers beyond the last DIF stage behave like the last one.
    function automatic logic [2:0] stage_clamp(input logic [2:0] s);
        return (s > 3'd4) ? 3'd4 : s;
    endfunction

    function automatic logic [3:0] twiddle_exp(input logic [2:0] s, input logic [LOG2N-1:0] n);
        logic [5:0] span;
        logic [5:0] half;
        logic [5:0] p;
        logic [5:0] k;
        span = 6'(FFT_N) >> s;
        half = span >> 1;
        p    = {1'b0, n} & (span - 6'd1);
        if (p >= half) k = (p - half) << s;
        else           k = 6'd0;
        return k[3:0];
    endfunction

    // Half-up rounding of a Q2.18-scaled product back to sample scale.
    function automatic logic signed [OUT_W-1:0] round_q(input logic signed [PROD_W-1:0] x);
        logic signed [PROD_W-1:0] t;
        t = x + $signed({{(PROD_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}});
        t = t >>> TW_FRAC;
        return t[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fft32_twiddle_scheduler_if.sv
// Frame-control, input-stream and output-stream signals of the twiddle scheduler.
interface fft32_twiddle_scheduler_if;
    import fft32_pkg::*;

    logic                    start;
    logic [2:0]              stage;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_real;
    logic signed [IN_W-1:0]  in_imag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_real;
    logic signed [OUT_W-1:0] out_imag;
    logic [LOG2N-1:0]        out_index;
    logic                    frame_done;

    modport master (
        output start, stage, in_valid, in_real, in_imag, out_ready,
        input  busy, in_ready, out_valid, out_real, out_imag, out_index, frame_done
    );

    modport slave (
        input  start, stage, in_valid, in_real, in_imag, out_ready,
        output busy, in_ready, out_valid, out_real, out_imag, out_index, frame_done
    );

endinterface

// File: rtl/complex_mult.sv
// Full-precision combinational complex multiplier (a * b), result one bit wider than the raw products.
module complex_mult #(
    parameter int inWordWidth_1 = 18,
    parameter int inWordWidth_2 = 20
) (
    input  logic signed [inWordWidth_1-1:0]               a_real,
    input  logic signed [inWordWidth_1-1:0]               a_imag,
    input  logic signed [inWordWidth_2-1:0]               b_real,
    input  logic signed [inWordWidth_2-1:0]               b_imag,
    output logic signed [inWordWidth_1+inWordWidth_2:0]   p_real,
    output logic signed [inWordWidth_1+inWordWidth_2:0]   p_imag
);

    localparam int PW = inWordWidth_1 + inWordWidth_2 + 1;

    logic signed [PW-1:0] ar_s, ai_s, br_s, bi_s;

    assign ar_s   = PW'(a_real);
    assign ai_s   = PW'(a_imag);
    assign br_s   = PW'(b_real);
    assign bi_s   = PW'(b_imag);
    assign p_real = ar_s * br_s - ai_s * bi_s;
    assign p_imag = ar_s * bi_s + ai_s * br_s;

endmodule

// File: rtl/fft32_twiddle_rom.sv
// W32^k for k=0..15 in Q2.18 (cos - j*sin), synchronous read with hold enable.
module fft32_twiddle_rom
    import fft32_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3:0]             addr,
    output logic signed [TW_W-1:0] tw_real,
    output logic signed [TW_W-1:0] tw_imag
);

    logic signed [TW_W-1:0] re_s;
    logic signed [TW_W-1:0] im_s;

    // Table lookup, round-to-nearest of 2^18*cos and -2^18*sin of 2*pi*k/32.
    always_comb begin
        re_s = 20'sd0;
        im_s = 20'sd0;
        case (addr)
            4'd0:    begin re_s =  20'sd262144; im_s =  20'sd0;      end
            4'd1:    begin re_s =  20'sd257107; im_s = -20'sd51142;  end
            4'd2:    begin re_s =  20'sd242189; im_s = -20'sd100318; end
            4'd3:    begin re_s =  20'sd217965; im_s = -20'sd145639; end
            4'd4:    begin re_s =  20'sd185364; im_s = -20'sd185364; end
            4'd5:    begin re_s =  20'sd145639; im_s = -20'sd217965; end
            4'd6:    begin re_s =  20'sd100318; im_s = -20'sd242189; end
            4'd7:    begin re_s =  20'sd51142;  im_s = -20'sd257107; end
            4'd8:    begin re_s =  20'sd0;      im_s = -20'sd262144; end
            4'd9:    begin re_s = -20'sd51142;  im_s = -20'sd257107; end
            4'd10:   begin re_s = -20'sd100318; im_s = -20'sd242189; end
            4'd11:   begin re_s = -20'sd145639; im_s = -20'sd217965; end
            4'd12:   begin re_s = -20'sd185364; im_s = -20'sd185364; end
            4'd13:   begin re_s = -20'sd217965; im_s = -20'sd145639; end
            4'd14:   begin re_s = -20'sd242189; im_s = -20'sd100318; end
            4'd15:   begin re_s = -20'sd257107; im_s = -20'sd51142;  end
            default: begin re_s =  20'sd0;      im_s =  20'sd0;      end
        endcase
    end

    // Read register; held while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_real <= 20'sd0;
            tw_imag <= 20'sd0;
        end else if (en) begin
            tw_real <= re_s;
            tw_imag <= im_s;
        end
    end

endmodule

// File: rtl/fft32_twiddle_scheduler.sv
// One DIF stage pass: stamps each of 32 samples with its twiddle exponent and streams
// x[n] * W32^k out through a 3-deep stallable pipeline (index, ROM fetch, round).
module fft32_twiddle_scheduler
    import fft32_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    fft32_twiddle_scheduler_if.slave  bus
);

    state_t                  state_r, state_s;
    logic [2:0]              stage_r;
    logic [LOG2N-1:0]        n_r;
    logic                    busy_r;
    logic                    stall_s, in_ready_s, in_hs_s, out_hs_s, frame_done_s;

    logic                    p1_valid_r;
    logic signed [IN_W-1:0]  p1_real_r, p1_imag_r;
    logic [LOG2N-1:0]        p1_index_r;
    logic [3:0]              p1_k_r;

    logic                    p2_valid_r;
    logic signed [IN_W-1:0]  p2_real_r, p2_imag_r;
    logic [LOG2N-1:0]        p2_index_r;
    logic signed [TW_W-1:0]  tw_real_s, tw_imag_s;
    logic signed [PROD_W-1:0] prod_real_s, prod_imag_s;

    logic                    out_valid_r;
    logic signed [OUT_W-1:0] out_real_r, out_imag_r;
    logic [LOG2N-1:0]        out_index_r;

    assign stall_s    = out_valid_r && !bus.out_ready;
    assign in_ready_s = (state_r == ST_RUN) && !stall_s;
    assign in_hs_s    = bus.in_valid && in_ready_s;
    assign out_hs_s   = out_valid_r && bus.out_ready;

    // Frame sequencing: accept 32 inputs, then wait for sample 31 to leave.
    always_comb begin
        state_s      = state_r;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_RUN;
                else           state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (in_hs_s && (n_r == 5'd31)) state_s = ST_DRAIN;
                else                           state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (out_hs_s && (out_index_r == 5'd31)) begin
                    state_s      = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_s      = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, latched stage and input sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            stage_r <= 3'd0;
            n_r     <= 5'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            if ((state_r == ST_IDLE) && bus.start) begin
                stage_r <= stage_clamp(bus.stage);
                n_r     <= 5'd0;
            end else if (in_hs_s) begin
                n_r     <= n_r + 5'd1;
            end
        end
    end

    fft32_twiddle_rom u_rom (
        .clk     (clk),
        .rst     (rst),
        .en      (!stall_s),
        .addr    (p1_k_r),
        .tw_real (tw_real_s),
        .tw_imag (tw_imag_s)
    );

    complex_mult #(
        .inWordWidth_1 (IN_W),
        .inWordWidth_2 (TW_W)
    ) u_cmul (
        .a_real (p2_real_r),
        .a_imag (p2_imag_r),
        .b_real (tw_real_s),
        .b_imag (tw_imag_s),
        .p_real (prod_real_s),
        .p_imag (prod_imag_s)
    );

    // Pipeline stages P1..P3; a stall freezes every stage together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid_r  <= 1'b0;
            p1_real_r   <= 18'sd0;
            p1_imag_r   <= 18'sd0;
            p1_index_r  <= 5'd0;
            p1_k_r      <= 4'd0;
            p2_valid_r  <= 1'b0;
            p2_real_r   <= 18'sd0;
            p2_imag_r   <= 18'sd0;
            p2_index_r  <= 5'd0;
            out_valid_r <= 1'b0;
            out_real_r  <= 19'sd0;
            out_imag_r  <= 19'sd0;
            out_index_r <= 5'd0;
        end else if (!stall_s) begin
            p1_valid_r <= in_hs_s;
            if (in_hs_s) begin
                p1_real_r  <= bus.in_real;
                p1_imag_r  <= bus.in_imag;
                p1_index_r <= n_r;
                p1_k_r     <= twiddle_exp(stage_r, n_r);
            end
            p2_valid_r  <= p1_valid_r;
            p2_real_r   <= p1_real_r;
            p2_imag_r   <= p1_imag_r;
            p2_index_r  <= p1_index_r;
            out_valid_r <= p2_valid_r;
            if (p2_valid_r) begin
                out_real_r  <= round_q(prod_real_s);
                out_imag_r  <= round_q(prod_imag_s);
                out_index_r <= p2_index_r;
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_real   = out_real_r;
    assign bus.out_imag   = out_imag_r;
    assign bus.out_index  = out_index_r;
    assign bus.frame_done = frame_done_s;

endmodule

// File: tb/tb_fft32_twiddle_scheduler.sv
// Randomized bench for fft32_twiddle_scheduler against a floating-point twiddle reference.
module tb_fft32_twiddle_scheduler;
    import fft32_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft32_twiddle_scheduler_if bus();

    fft32_twiddle_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint re;
        longint im;
        int     idx;
    } exp_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   sb[$];
    int     in_re[32];
    int     in_im[32];
    longint got_re[32];
    longint got_im[32];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint q18(input real x);
        if (x >= 0.0) return longint'($rtoi($floor(x + 0.5)));
        else          return -longint'($rtoi($floor(-x + 0.5)));
    endfunction

    function automatic int tw_k(input int s, input int n);
        int ss, half, p;
        ss   = (s > 4) ? 4 : s;
        half = 16 >> ss;
        p    = n % (32 >> ss);
        return (p >= half) ? ((p - half) << ss) : 0;
    endfunction

    task automatic model_push(input int s, input int n, input int re, input int im);
        real    ang;
        longint wr, wi, pr, pi_;
        exp_t   e;
        ang = 2.0 * 3.14159265358979323846 * real'(tw_k(s, n)) / 32.0;
        wr  = q18(262144.0 * $cos(ang));
        wi  = -q18(262144.0 * $sin(ang));
        pr  = longint'(re) * wr - longint'(im) * wi;
        pi_ = longint'(re) * wi + longint'(im) * wr;
        e.re  = (pr + 64'sd131072) >>> 18;
        e.im  = (pi_ + 64'sd131072) >>> 18;
        e.idx = n;
        sb.push_back(e);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            in_re[i] = int'($urandom_range(0, 262143)) - 131072;
            in_im[i] = int'($urandom_range(0, 262143)) - 131072;
        end
    endtask

    // One frame: random valid/ready pressure, optional forced stall window and mid-frame start pulse.
    task automatic run_frame(input int st, input int vpct, input int rpct, input int stall_at, input int restart_at);
        int     sent = 0, rcv = 0, cyc = 0, first_hs = -1, first_ov = -1, fd_cnt = 0;
        bit     prev_stall = 1'b0, stall, ihs, ohs;
        longint pre_re = 0, pre_im = 0, pre_idx = 0;
        exp_t   e;
        sb.delete();
        @(posedge clk); #1;
        bus.stage = 3'(st);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (rcv < 32 && cyc < 1000) begin
            check_val("busy_in_frame", bus.busy, 1);
            if (prev_stall) begin
                check_val("hold_valid", bus.out_valid, 1);
                check_val("hold_real", bus.out_real, pre_re);
                check_val("hold_imag", bus.out_imag, pre_im);
                check_val("hold_index", bus.out_index, pre_idx);
            end
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (cyc >= stall_at && cyc < stall_at + 5) bus.out_ready = 1'b0;
            else bus.out_ready = ($urandom_range(1, 100) <= rpct);
            bus.in_valid = (sent < 32) && ($urandom_range(1, 100) <= vpct);
            bus.in_real  = IN_W'(in_re[(sent < 32) ? sent : 0]);
            bus.in_imag  = IN_W'(in_im[(sent < 32) ? sent : 0]);
            bus.start    = (cyc == restart_at);
            if (cyc == restart_at) bus.stage = 3'd3;
            #1;
            stall = bus.out_valid && !bus.out_ready;
            check_val("in_ready", bus.in_ready, !stall && (sent < 32));
            ihs = bus.in_valid && bus.in_ready;
            ohs = bus.out_valid && bus.out_ready;
            if (ihs) begin
                model_push(st, sent, in_re[sent], in_im[sent]);
                if (first_hs < 0) first_hs = cyc;
                sent++;
            end
            check_val("frame_done", bus.frame_done, ohs && (rcv == 31));
            if (bus.frame_done) fd_cnt++;
            if (ohs) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("out_index", bus.out_index, e.idx);
                    check_val("out_real", bus.out_real, e.re);
                    check_val("out_imag", bus.out_imag, e.im);
                    got_re[e.idx] = bus.out_real;
                    got_im[e.idx] = bus.out_imag;
                end
                rcv++;
            end
            prev_stall = stall;
            pre_re  = bus.out_real;
            pre_im  = bus.out_imag;
            pre_idx = bus.out_index;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check_val("frame_rcv_count", rcv, 32);
        check_val("first_latency", first_ov - first_hs, 3);
        check_val("frame_done_count", fd_cnt, 1);
        check_val("busy_after_done", bus.busy, 0);
        check_val("valid_after_done", bus.out_valid, 0);
        check_val("sb_empty", sb.size(), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.stage = 3'd0; bus.in_valid = 1'b0;
        bus.in_real = '0; bus.in_imag = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_frame_done", bus.frame_done, 0);
        check_val("rst_out_real", bus.out_real, 0);
        check_val("rst_out_imag", bus.out_imag, 0);
        check_val("rst_out_index", bus.out_index, 0);
        rst = 1'b0;

        // Stage 0, full throughput, with directed samples.
        fill_random();
        in_re[16] = 1000;   in_im[16] = 0;
        in_re[24] = 1000;   in_im[24] = 0;
        in_re[20] = 131071; in_im[20] = 131071;
        run_frame(0, 100, 100, -1, -1);
        check_val("s0_n16_re", got_re[16], 1000);
        check_val("s0_n16_im", got_im[16], 0);
        check_val("s0_n24_re", got_re[24], 0);
        check_val("s0_n24_im", got_im[24], -1000);
        check_val("s0_n20_re", got_re[20], 185363);
        check_val("s0_n20_im", got_im[20], 0);

        // Stage 1 with bubbles and backpressure.
        fill_random();
        in_re[12] = 0; in_im[12] = 500;
        run_frame(1, 70, 70, -1, -1);
        check_val("s1_n12_re", got_re[12], 500);
        check_val("s1_n12_im", got_im[12], 0);

        // Stage 4 and an out-of-range stage both pass samples unchanged.
        fill_random();
        run_frame(4, 80, 100, -1, -1);
        for (int i = 0; i < 32; i++) begin
            check_val("s4_identity_re", got_re[i], in_re[i]);
            check_val("s4_identity_im", got_im[i], in_im[i]);
        end
        fill_random();
        run_frame(6, 90, 60, -1, -1);
        for (int i = 0; i < 32; i++) check_val("s6_identity_re", got_re[i], in_re[i]);

        // Five-cycle output stall mid-frame.
        fill_random();
        run_frame(2, 100, 100, 10, -1);

        fill_random();
        run_frame(3, 50, 50, -1, -1);

        // Reset with ten samples accepted.
        fill_random();
        @(posedge clk); #1;
        bus.stage = 3'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_real  = IN_W'(in_re[i]);
            bus.in_imag  = IN_W'(in_im[i]);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", bus.out_valid, 0);
        check_val("midrst_busy", bus.busy, 0);
        check_val("midrst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("postrst_busy", bus.busy, 0);
        check_val("postrst_out_valid", bus.out_valid, 0);
        check_val("postrst_frame_done", bus.frame_done, 0);

        // Start pulse with a different stage while busy must be ignored.
        fill_random();
        run_frame(1, 100, 100, -1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
